// File: rtl/accum_pkg.sv
// Shared state encoding and saturating-add helper for the accumulator bank array.
// Saturation is used only when ACCUM_SATURATE_EN is defined.
package accum_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int SAT_W = 64;

  // Operands arrive sign-extended from a w-bit value, so the wide sum cannot overflow.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input  logic signed [SAT_W-1:0] a,
    input  logic signed [SAT_W-1:0] b,
    input  int                      w,
    output logic                    clamped
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum     = a + b;
    hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (w - 1));
    clamped = 1'b0;
    if (sum > hi) begin
      sat_add = hi;
      clamped = 1'b1;
    end else if (sum < lo) begin
      sat_add = lo;
      clamped = 1'b1;
    end else begin
      sat_add = sum;
    end
  endfunction

endpackage

// File: rtl/accum_bank_array_if.sv
// Bus bundle for accum_bank_array: clear control plus per-column write/read lanes.
// Column c occupies slice c of every packed vector, column 0 in the LSBs.
interface accum_bank_array_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int NUM_COLS   = 16,
  parameter int DEPTH      = 1024
);
  localparam int AW = $clog2(DEPTH);

  logic                           clr_start;
  logic                           clr_busy;
  logic [NUM_COLS-1:0]            wr_en;
  logic [NUM_COLS-1:0]            wr_mode;
  logic [AW*NUM_COLS-1:0]         wr_addr;
  logic [DATA_WIDTH*NUM_COLS-1:0] wr_data;
  logic [NUM_COLS-1:0]            rd_en;
  logic [AW*NUM_COLS-1:0]         rd_addr;
  logic [ACC_WIDTH*NUM_COLS-1:0]  rd_data;
  logic [NUM_COLS-1:0]            rd_valid;
  logic [NUM_COLS-1:0]            ovf;

  modport master (
    output clr_start, wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr,
    input  clr_busy, rd_data, rd_valid, ovf
  );

  modport slave (
    input  clr_start, wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr,
    output clr_busy, rd_data, rd_valid, ovf
  );

endinterface

// File: rtl/accum_bank.sv
// One accumulator column: row memory with same-edge read-modify-write, registered read, sticky ovf.
// ACCUM_SATURATE_EN selects clamping accumulate with ovf tracking; otherwise accumulate wraps.
module accum_bank
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int DEPTH      = 1024,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr_en,
  input  logic [AW-1:0]                clr_addr,
`ifdef ACCUM_SATURATE_EN
  input  logic                         ovf_clr,
`endif
  input  logic                         wr_en,
  input  logic                         wr_mode,
  input  logic [AW-1:0]                wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic                         rd_en,
  input  logic [AW-1:0]                rd_addr,
  output logic signed [ACC_WIDTH-1:0]  rd_data,
  output logic                         rd_valid,
  output logic                         ovf
);

  logic signed [ACC_WIDTH-1:0] mem [DEPTH];
  logic signed [ACC_WIDTH-1:0] old_val;
  logic signed [ACC_WIDTH-1:0] ext_data;
  logic signed [ACC_WIDTH-1:0] acc_val;
  logic signed [ACC_WIDTH-1:0] new_val;

  assign old_val  = mem[wr_addr];
  assign ext_data = ACC_WIDTH'(wr_data);

`ifdef ACCUM_SATURATE_EN
  logic                    clamped;
  logic signed [SAT_W-1:0] sat_sum;

  always_comb begin
    clamped = 1'b0;
    sat_sum = sat_add(SAT_W'(old_val), SAT_W'(ext_data), ACC_WIDTH, clamped);
    acc_val = ACC_WIDTH'(sat_sum);
  end

  always_ff @(posedge clk) begin
    if (reset || ovf_clr) begin
      ovf <= 1'b0;
    end else if (wr_en && wr_mode && clamped) begin
      ovf <= 1'b1;
    end
  end
`else
  assign acc_val = old_val + ext_data;
  assign ovf     = 1'b0;
`endif

  assign new_val = wr_mode ? acc_val : ext_data;

  // The sweep owns the write port; the top already masks user writes while it runs.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= new_val;
    end
  end

  // Non-blocking update of mem gives read-before-write on a same-row collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/accum_bank_array.sv
// Array of NUM_COLS independent accumulator columns sharing one zeroing-sweep FSM.
// Define ACCUM_SATURATE_EN to build with saturating accumulate and per-column ovf.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | user reads/writes accepted; clr_start launches a sweep
// ST_CLEAR | row_q is zeroed in every column each cycle; user access masked
module accum_bank_array
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int NUM_COLS   = 16,
  parameter int DEPTH      = 1024,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  accum_bank_array_if.slave  bus
);

  state_t              state_q;
  state_t              state_d;
  logic [AW-1:0]       row_q;
  logic [AW-1:0]       row_d;
  logic                clr_busy;
  logic [NUM_COLS-1:0] wr_en_ok;
  logic [NUM_COLS-1:0] rd_en_ok;

  logic [ACC_WIDTH*NUM_COLS-1:0] rd_data_all;
  logic [NUM_COLS-1:0]           rd_valid_all;
  logic [NUM_COLS-1:0]           ovf_all;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_start) begin
          state_d = ST_CLEAR;
          row_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (row_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          row_d   = '0;
        end else begin
          row_d = row_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_CLEAR;
        row_d   = '0;
      end
    endcase
  end

  assign clr_busy = (state_q == ST_CLEAR);
  assign wr_en_ok = bus.wr_en & {NUM_COLS{~clr_busy}};
  assign rd_en_ok = bus.rd_en & {NUM_COLS{~clr_busy}};

`ifdef ACCUM_SATURATE_EN
  logic clr_entry;
  assign clr_entry = (state_q == ST_IDLE) && bus.clr_start;
`endif

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    accum_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .DEPTH      (DEPTH)
    ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .clr_en   (clr_busy),
      .clr_addr (row_q),
`ifdef ACCUM_SATURATE_EN
      .ovf_clr  (clr_entry),
`endif
      .wr_en    (wr_en_ok[c]),
      .wr_mode  (bus.wr_mode[c]),
      .wr_addr  (bus.wr_addr[c*AW +: AW]),
      .wr_data  (bus.wr_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en    (rd_en_ok[c]),
      .rd_addr  (bus.rd_addr[c*AW +: AW]),
      .rd_data  (rd_data_all[c*ACC_WIDTH +: ACC_WIDTH]),
      .rd_valid (rd_valid_all[c]),
      .ovf      (ovf_all[c])
    );
  end

  assign bus.clr_busy = clr_busy;
  assign bus.rd_data  = rd_data_all;
  assign bus.rd_valid = rd_valid_all;
  assign bus.ovf      = ovf_all;

endmodule

// File: tb/tb_accum_bank_array.sv
// Directed bench for accum_bank_array: a default-size array plus a narrow 8-bit array
// for accumulate overflow behaviour (expectations follow ACCUM_SATURATE_EN).
module tb_accum_bank_array;

  localparam int DW    = 8;
  localparam int ACC   = 24;
  localparam int NC    = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  localparam int S_ACC   = 8;
  localparam int S_NC    = 2;
  localparam int S_DEPTH = 16;
  localparam int S_AW    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int vectors     = 0;
  int miscompares = 0;

  accum_bank_array_if #(.DATA_WIDTH(DW), .ACC_WIDTH(ACC), .NUM_COLS(NC), .DEPTH(DEPTH)) bus ();
  accum_bank_array_if #(.DATA_WIDTH(DW), .ACC_WIDTH(S_ACC), .NUM_COLS(S_NC), .DEPTH(S_DEPTH)) sbus ();

  accum_bank_array #(.DATA_WIDTH(DW), .ACC_WIDTH(ACC), .NUM_COLS(NC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  accum_bank_array #(.DATA_WIDTH(DW), .ACC_WIDTH(S_ACC), .NUM_COLS(S_NC), .DEPTH(S_DEPTH)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clr_start  = 1'b0;
    bus.wr_en      = '0;
    bus.wr_mode    = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.rd_en      = '0;
    bus.rd_addr    = '0;
    sbus.clr_start = 1'b0;
    sbus.wr_en     = '0;
    sbus.wr_mode   = '0;
    sbus.wr_addr   = '0;
    sbus.wr_data   = '0;
    sbus.rd_en     = '0;
    sbus.rd_addr   = '0;
  endtask

  task automatic set_write(input int c, input int addr, input int data, input logic mode);
    bus.wr_en[c]              = 1'b1;
    bus.wr_mode[c]            = mode;
    bus.wr_addr[c*AW +: AW]   = AW'(addr);
    bus.wr_data[c*DW +: DW]   = DW'(data);
  endtask

  task automatic set_read(input int c, input int addr);
    bus.rd_en[c]            = 1'b1;
    bus.rd_addr[c*AW +: AW] = AW'(addr);
  endtask

  task automatic s_set_write(input int c, input int addr, input int data, input logic mode);
    sbus.wr_en[c]                 = 1'b1;
    sbus.wr_mode[c]               = mode;
    sbus.wr_addr[c*S_AW +: S_AW]  = S_AW'(addr);
    sbus.wr_data[c*DW +: DW]      = DW'(data);
  endtask

  function automatic logic [ACC-1:0] col_data(input int c);
    return bus.rd_data[c*ACC +: ACC];
  endfunction

  task automatic count_busy(output int n);
    n = 0;
    while (bus.clr_busy === 1'b1 && n < 4000) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    logic [NC-1:0] ev;
    reset = 1'b1;
    idle_inputs();
    repeat (3) tick();
    vectors++;
    if (bus.clr_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_busy: got %0b expected 1", bus.clr_busy);
    end
    vectors++;
    if (bus.rd_valid !== '0 || bus.rd_data !== '0) begin
      miscompares++;
      $display("FAIL reset_rd: rd_valid %h rd_data %h expected 0", bus.rd_valid, bus.rd_data);
    end
    vectors++;
    if (bus.ovf !== '0 || sbus.ovf !== '0) begin
      miscompares++;
      $display("FAIL reset_ovf: got %h/%h expected 0", bus.ovf, sbus.ovf);
    end
    reset = 1'b0;
    count_busy(n);
    vectors++;
    if (n !== 1024) begin
      miscompares++;
      $display("FAIL reset_sweep_len: got %0d cycles expected 1024", n);
    end
    vectors++;
    if (sbus.clr_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL small_sweep_done: got %0b expected 0", sbus.clr_busy);
    end
    set_read(0, 0);
    set_read(9, 512);
    set_read(15, 1023);
    tick();
    idle_inputs();
    ev = '0;
    ev[0] = 1'b1; ev[9] = 1'b1; ev[15] = 1'b1;
    vectors++;
    if (bus.rd_valid !== ev) begin
      miscompares++;
      $display("FAIL reset_read_valid: got %h expected %h", bus.rd_valid, ev);
    end
    vectors++;
    if (col_data(0) !== '0 || col_data(9) !== '0 || col_data(15) !== '0) begin
      miscompares++;
      $display("FAIL reset_read_zero: got %h %h %h expected 0", col_data(0), col_data(9), col_data(15));
    end
  endtask

  task automatic test_overwrite_accumulate();
    logic [NC-1:0] ev;
    set_write(3, 5, 10, 1'b0);
    tick();
    idle_inputs();
    set_write(3, 5, -3, 1'b1);
    tick();
    tick();
    idle_inputs();
    set_read(3, 5);
    set_read(4, 5);
    tick();
    idle_inputs();
    ev = '0;
    ev[3] = 1'b1; ev[4] = 1'b1;
    vectors++;
    if (col_data(3) !== ACC'(4)) begin
      miscompares++;
      $display("FAIL acc_col3: got %0d expected 4", $signed(col_data(3)));
    end
    vectors++;
    if (bus.rd_valid !== ev) begin
      miscompares++;
      $display("FAIL acc_valid: got %h expected %h", bus.rd_valid, ev);
    end
    vectors++;
    if (col_data(4) !== '0) begin
      miscompares++;
      $display("FAIL col_isolation: got %0d expected 0", $signed(col_data(4)));
    end
    tick();
    vectors++;
    if (bus.rd_valid !== '0 || col_data(3) !== ACC'(4)) begin
      miscompares++;
      $display("FAIL rd_hold: valid %h data %0d expected 0 / 4", bus.rd_valid, $signed(col_data(3)));
    end
  endtask

  task automatic test_same_cycle_rw();
    set_write(0, 5, 4, 1'b0);
    tick();
    idle_inputs();
    set_write(0, 5, 7, 1'b1);
    set_read(0, 5);
    tick();
    idle_inputs();
    vectors++;
    if (col_data(0) !== ACC'(4) || bus.rd_valid[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rw_collision: got %0d valid %0b expected 4 valid 1", $signed(col_data(0)), bus.rd_valid[0]);
    end
    set_read(0, 5);
    tick();
    idle_inputs();
    vectors++;
    if (col_data(0) !== ACC'(11)) begin
      miscompares++;
      $display("FAIL rw_after: got %0d expected 11", $signed(col_data(0)));
    end
  endtask

  task automatic test_columns_independent();
    set_write(1, 100, -50, 1'b0);
    set_write(2, 200, 100, 1'b0);
    set_write(15, 1023, -128, 1'b0);
    tick();
    idle_inputs();
    set_write(1, 100, -50, 1'b1);
    set_write(2, 200, 27, 1'b1);
    set_write(15, 1023, -128, 1'b1);
    tick();
    idle_inputs();
    set_read(1, 100);
    set_read(2, 200);
    set_read(15, 1023);
    tick();
    idle_inputs();
    vectors++;
    if (col_data(1) !== ACC'(-100)) begin
      miscompares++;
      $display("FAIL multi_col1: got %0d expected -100", $signed(col_data(1)));
    end
    vectors++;
    if (col_data(2) !== ACC'(127)) begin
      miscompares++;
      $display("FAIL multi_col2: got %0d expected 127", $signed(col_data(2)));
    end
    vectors++;
    if (col_data(15) !== ACC'(-256)) begin
      miscompares++;
      $display("FAIL multi_col15: got %0d expected -256", $signed(col_data(15)));
    end
  endtask

  task automatic test_saturate();
    logic [S_ACC-1:0]  exp0;
    logic [S_ACC-1:0]  exp1;
    logic [S_NC-1:0]   expo;
    int n;
`ifdef ACCUM_SATURATE_EN
    exp0 = S_ACC'(127);
    exp1 = S_ACC'(-128);
    expo = 2'b11;
`else
    exp0 = S_ACC'(-116);
    exp1 = S_ACC'(56);
    expo = 2'b00;
`endif
    s_set_write(0, 3, 120, 1'b0);
    s_set_write(1, 4, -100, 1'b0);
    tick();
    idle_inputs();
    s_set_write(0, 3, 20, 1'b1);
    s_set_write(1, 4, -100, 1'b1);
    tick();
    idle_inputs();
    sbus.rd_en = 2'b11;
    sbus.rd_addr[0 +: S_AW]    = S_AW'(3);
    sbus.rd_addr[S_AW +: S_AW] = S_AW'(4);
    tick();
    idle_inputs();
    vectors++;
    if (sbus.rd_data[0 +: S_ACC] !== exp0) begin
      miscompares++;
      $display("FAIL sat_pos: got %0d expected %0d", $signed(sbus.rd_data[0 +: S_ACC]), $signed(exp0));
    end
    vectors++;
    if (sbus.rd_data[S_ACC +: S_ACC] !== exp1) begin
      miscompares++;
      $display("FAIL sat_neg: got %0d expected %0d", $signed(sbus.rd_data[S_ACC +: S_ACC]), $signed(exp1));
    end
    vectors++;
    if (sbus.ovf !== expo) begin
      miscompares++;
      $display("FAIL sat_ovf: got %b expected %b", sbus.ovf, expo);
    end
    sbus.clr_start = 1'b1;
    tick();
    sbus.clr_start = 1'b0;
    vectors++;
    if (sbus.ovf !== '0 || sbus.clr_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_ovf_clear: ovf %b busy %0b expected 00 / 1", sbus.ovf, sbus.clr_busy);
    end
    n = 0;
    while (sbus.clr_busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL small_sweep_len: got %0d expected 16", n);
    end
  endtask

  task automatic test_clear_sweep();
    int  n;
    logic rv_seen;
    set_write(6, 9, 55, 1'b0);
    tick();
    idle_inputs();
    set_read(6, 9);
    tick();
    idle_inputs();
    vectors++;
    if (col_data(6) !== ACC'(55)) begin
      miscompares++;
      $display("FAIL pre_sweep: got %0d expected 55", $signed(col_data(6)));
    end
    bus.clr_start = 1'b1;
    tick();
    idle_inputs();
    n = 0;
    rv_seen = 1'b0;
    while (bus.clr_busy === 1'b1 && n < 4000) begin
      idle_inputs();
      if (n == 3) begin
        set_write(6, 2, 77, 1'b0);
        set_read(6, 2);
      end
      if (n == 100) bus.clr_start = 1'b1;
      tick();
      n++;
      if (bus.rd_valid !== '0) rv_seen = 1'b1;
    end
    idle_inputs();
    vectors++;
    if (n !== 1024) begin
      miscompares++;
      $display("FAIL sweep_len_restart_ignored: got %0d expected 1024", n);
    end
    vectors++;
    if (rv_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_rd_masked: got rd_valid during sweep, expected none");
    end
    set_read(6, 2);
    tick();
    idle_inputs();
    vectors++;
    if (col_data(6) !== '0) begin
      miscompares++;
      $display("FAIL sweep_wr_masked: got %0d expected 0", $signed(col_data(6)));
    end
    set_read(6, 9);
    tick();
    idle_inputs();
    vectors++;
    if (col_data(6) !== '0) begin
      miscompares++;
      $display("FAIL sweep_zeroed: got %0d expected 0", $signed(col_data(6)));
    end
  endtask

  task automatic test_reset_mid();
    int n;
    set_write(0, 1, 9, 1'b0);
    tick();
    idle_inputs();
    set_read(0, 1);
    reset = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if (bus.rd_valid !== '0 || bus.rd_data !== '0 || bus.clr_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_read: valid %h data %h busy %0b expected 0/0/1", bus.rd_valid, bus.rd_data, bus.clr_busy);
    end
    reset = 1'b0;
    count_busy(n);
    vectors++;
    if (n !== 1024) begin
      miscompares++;
      $display("FAIL reset_mid_read_len: got %0d expected 1024", n);
    end
    bus.clr_start = 1'b1;
    tick();
    idle_inputs();
    repeat (500) tick();
    vectors++;
    if (bus.clr_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL sweep_500_busy: got %0b expected 1", bus.clr_busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_busy(n);
    vectors++;
    if (n !== 1024) begin
      miscompares++;
      $display("FAIL reset_mid_sweep_len: got %0d expected 1024", n);
    end
    set_read(0, 1);
    tick();
    idle_inputs();
    vectors++;
    if (col_data(0) !== '0 || bus.rd_valid[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_zero: got %0d valid %0b expected 0 valid 1", $signed(col_data(0)), bus.rd_valid[0]);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_overwrite_accumulate();
    test_same_cycle_rw();
    test_columns_independent();
    test_saturate();
    test_clear_sweep();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
